// File: rtl/mat_reg_reader_pkg.sv
// Shared types for the matrix register and its read-side sequencer.
// Pure declarations, no latency of its own.
// No backpressure here; the users of these types handle flow control.
package mat_reg_reader_pkg;

  // Read-port operation understood by the matrix register.
  typedef enum logic [2:0] {
    MAT_DATA_READ_DISABLE = 3'd0,
    MAT_DATA_READ_SCALAR  = 3'd1,
    MAT_DATA_READ_ROW     = 3'd2,
    MAT_DATA_READ_COL     = 3'd3,
    MAT_DATA_READ_DIAG    = 3'd4
  } MatDataReadOp_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } MatReaderState_t;

  // One matrix element, carried as the raw IEEE-754 single-precision bit
  // pattern so the datapath stays plain flops and wires.
  typedef logic [31:0] fp32_t;

  // Only whole-vector reads can be streamed; scalar and disable are refused.
  function automatic logic op_is_vector(input MatDataReadOp_t op);
    return (op == MAT_DATA_READ_ROW) || (op == MAT_DATA_READ_COL) ||
           (op == MAT_DATA_READ_DIAG);
  endfunction

endpackage

// File: rtl/mat_reg_reader_out_buf.sv
// One-entry output register for vector, index and last flag (mat_out_buf).
// Latency: one cycle from load to out_valid.
// Backpressure: contents held while out_valid && !out_ready; reload on accept.
module mat_out_buf
  import mat_reg_reader_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load,
  input  fp32_t [WIDTH-1:0]          load_data,
  input  logic [WIDTH_ADDR_SIZE-1:0] load_index,
  input  logic                       load_last,
  input  logic                       out_ready,
  output logic                       out_valid,
  output fp32_t [WIDTH-1:0]          out_data,
  output logic [WIDTH_ADDR_SIZE-1:0] out_index,
  output logic                       out_last
);

  // Occupancy and last flag: clear wins, then a new load, then drain on accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Payload only changes on a load, so it is stable across any stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_index <= '0;
    end else if (load && !clear) begin
      out_data  <= load_data;
      out_index <= load_index;
    end
  end

endmodule

// File: rtl/mat_reg_reader.sv
// Walks the matrix register read port over consecutive rows/cols/diags and streams vectors.
// Latency: start sampled -> RUN next cycle -> first out_valid one cycle later; then 1 vector/cycle.
// Backpressure: read port idles (DISABLE) while the output register is full and not accepted.
// Optional: define MAT_READER_REVERSE_EN to allow descending index order via start_reverse.
module mat_reg_reader
  import mat_reg_reader_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  MatDataReadOp_t             start_op,
  input  logic [WIDTH_ADDR_SIZE-1:0] start_index,
  input  logic [WIDTH_ADDR_SIZE:0]   start_count,
  input  logic                       start_reverse,
  input  logic                       abort,
  output MatDataReadOp_t             read_op,
  output logic [WIDTH_ADDR_SIZE-1:0] read_param1,
  output logic [WIDTH_ADDR_SIZE-1:0] read_param2,
  input  fp32_t [WIDTH-1:0]          read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output fp32_t [WIDTH-1:0]          out_data,
  output logic [WIDTH_ADDR_SIZE-1:0] out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int CNT_W = WIDTH_ADDR_SIZE + 1;
  localparam logic [CNT_W-1:0]           CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_MAX  = WIDTH_ADDR_SIZE'(WIDTH - 1);
  localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_ONE  = WIDTH_ADDR_SIZE'(1);

  MatReaderState_t              state, state_nxt;
  MatDataReadOp_t               cur_op;
  logic [WIDTH_ADDR_SIZE-1:0]   cur_idx;
  logic [WIDTH_ADDR_SIZE-1:0]   idx_step;
  logic [CNT_W-1:0]             remaining;
  logic                         issue;
  logic                         start_ok;
  logic                         start_bad;

`ifdef MAT_READER_REVERSE_EN
  logic                         cur_rev;
`else
  logic                         reverse_unused;
  assign reverse_unused = start_reverse;
`endif

  // abort outranks start, so an aborting cycle neither launches nor rejects.
  assign start_ok    = (state == IDLE) && start && !abort && op_is_vector(start_op);
  assign start_bad   = (state == IDLE) && start && !abort && !op_is_vector(start_op);
  assign busy        = (state != IDLE);
  assign read_param2 = '0;

  // Next index: ascending with wrap, or descending with wrap when enabled.
  always_comb begin
    idx_step = (cur_idx == IDX_MAX) ? '0 : cur_idx + IDX_ONE;
`ifdef MAT_READER_REVERSE_EN
    if (cur_rev) begin
      idx_step = (cur_idx == '0) ? IDX_MAX : cur_idx - IDX_ONE;
    end
`endif
  end

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read-port drive and done; issue whenever the output slot frees up.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    done        = 1'b0;
    read_op     = MAT_DATA_READ_DISABLE;
    read_param1 = '0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!out_valid || out_ready) begin
          issue       = 1'b1;
          read_op     = cur_op;
          read_param1 = cur_idx;
          if (remaining == CNT_ONE) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  // Command context: captured on an accepted start, advanced on every issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_op    <= MAT_DATA_READ_DISABLE;
      cur_idx   <= '0;
      remaining <= '0;
`ifdef MAT_READER_REVERSE_EN
      cur_rev   <= 1'b0;
`endif
    end else if (start_ok) begin
      cur_op    <= start_op;
      cur_idx   <= start_index;
      remaining <= (start_count == '0) ? CNT_FULL : start_count;
`ifdef MAT_READER_REVERSE_EN
      cur_rev   <= start_reverse;
`endif
    end else if (issue) begin
      cur_idx   <= idx_step;
      remaining <= remaining - CNT_ONE;
    end
  end

  // Rejected commands produce a single registered error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= start_bad;
    end
  end

  mat_out_buf #(
    .WIDTH           (WIDTH),
    .WIDTH_ADDR_SIZE (WIDTH_ADDR_SIZE)
  ) u_out_buf (
    .clock      (clock),
    .reset      (reset),
    .clear      (abort),
    .load       (issue),
    .load_data  (read_data),
    .load_index (cur_idx),
    .load_last  (remaining == CNT_ONE),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_mat_reg_reader.sv
// Directed bench for mat_reg_reader with a 4x4 matrix m[i][j] = 4i+j.
// Commands and their expected output beats come from hand-filled tables.
// Multi-cycle corners (reset, abort, reject) are written out as sequences.
module tb_mat_reg_reader;
  import mat_reg_reader_pkg::*;

  localparam int W  = 4;
  localparam int AW = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  MatDataReadOp_t      start_op = MAT_DATA_READ_DISABLE;
  logic [AW-1:0]       start_index = '0;
  logic [AW:0]         start_count = '0;
  logic                start_reverse = 1'b0;
  logic                abort = 1'b0;
  MatDataReadOp_t      read_op;
  logic [AW-1:0]       read_param1, read_param2;
  fp32_t [W-1:0]       read_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  fp32_t [W-1:0]       out_data;
  logic [AW-1:0]       out_index;
  logic                out_last, busy, done, error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int e0, e1, e2, e3;
    bit last;
  } beat_t;

  typedef struct {
    MatDataReadOp_t op;
    int idx;
    int cnt;
    bit rev;
    int nbeats;
    int first_beat;
    int stall_beat;
    int stall_len;
  } cmd_t;

  beat_t beats[16];
  cmd_t  cmds[8];

  always #5 clock = ~clock;

  mat_reg_reader #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .start_op     (start_op),
    .start_index  (start_index),
    .start_count  (start_count),
    .start_reverse(start_reverse),
    .abort        (abort),
    .read_op      (read_op),
    .read_param1  (read_param1),
    .read_param2  (read_param2),
    .read_data    (read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // Small non-negative integer to single-precision bit pattern.
  function automatic fp32_t i2f(input int n);
    int msb;
    fp32_t r;
    if (n == 0) return 32'h0;
    msb = 0;
    for (int b = 0; b < 16; b++) if (n >= (1 << b)) msb = b;
    r = '0;
    r[30:23] = 8'(127 + msb);
    r[22:0]  = 23'((n << (23 - msb)) & 32'h007F_FFFF);
    return r;
  endfunction

  // Combinational matrix register model; diagonal d is m[i][(i+d)%W].
  always_comb begin
    for (int j = 0; j < W; j++) begin
      case (read_op)
        MAT_DATA_READ_ROW:  read_data[j] = i2f(W * int'(read_param1) + j);
        MAT_DATA_READ_COL:  read_data[j] = i2f(W * j + int'(read_param1));
        MAT_DATA_READ_DIAG: read_data[j] = i2f(W * j + ((j + int'(read_param1)) % W));
        default:            read_data[j] = '0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input beat_t b);
    int e[4];
    e = '{b.e0, b.e1, b.e2, b.e3};
    chk("out_index", out_index, b.idx);
    chk("out_last", out_last, b.last);
    for (int j = 0; j < W; j++) chk($sformatf("out_data[%0d]", j), out_data[j], i2f(e[j]));
  endtask

  // Issue one command, consume its beats (with optional stall), then check return to idle.
  task automatic run_cmd(input cmd_t c);
    int bi;
    int stall;
    bi    = 0;
    stall = 0;
    start         = 1'b1;
    start_op      = c.op;
    start_index   = AW'(c.idx);
    start_count   = (AW + 1)'(c.cnt);
    start_reverse = c.rev;
    out_ready     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    chk("out_valid_in_run", out_valid, 0);
    chk("read_op_first", read_op, c.op);
    chk("read_param1_first", read_param1, c.idx);
    for (int cyc = 2; cyc < 32; cyc++) begin
      @(posedge clock); #1;
      if (out_valid && bi == c.stall_beat && stall < c.stall_len) begin
        out_ready = 1'b0;
        start     = 1'b1;
        start_op  = MAT_DATA_READ_COL;
        stall++;
      end else begin
        out_ready = 1'b1;
        start     = 1'b0;
      end
      #1;
      chk("out_valid_stream", out_valid, 1);
      if (!out_valid) break;
      if (bi == 0 && stall == 0) chk("first_valid_cycle", cyc, 2);
      chk_beat(beats[c.first_beat + bi]);
      if (!out_ready) begin
        chk("read_op_stalled", read_op, MAT_DATA_READ_DISABLE);
        chk("done_stalled", done, 0);
        continue;
      end
      chk("done_flag", done, beats[c.first_beat + bi].last);
      bi++;
      if (bi == c.nbeats) begin
        chk("done_cycle", cyc, c.nbeats + 1 + stall);
        break;
      end
    end
    chk("beats_seen", bi, c.nbeats);
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("busy_end", busy, 0);
    chk("out_valid_end", out_valid, 0);
    chk("done_end", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beats[0]  = '{1, 4, 5, 6, 7, 0};
    beats[1]  = '{2, 8, 9, 10, 11, 1};
    beats[2]  = '{3, 3, 7, 11, 15, 0};
    beats[3]  = '{0, 0, 4, 8, 12, 1};
    beats[4]  = '{0, 0, 1, 2, 3, 0};
    beats[5]  = '{1, 4, 5, 6, 7, 0};
    beats[6]  = '{2, 8, 9, 10, 11, 0};
    beats[7]  = '{3, 12, 13, 14, 15, 1};
    beats[8]  = '{2, 2, 7, 8, 13, 1};
    beats[9]  = '{1, 4, 5, 6, 7, 0};
    beats[10] = '{2, 8, 9, 10, 11, 0};
    beats[11] = '{3, 12, 13, 14, 15, 1};
    beats[12] = '{2, 8, 9, 10, 11, 1};
    beats[13] = '{0, 0, 1, 2, 3, 0};
    beats[14] = '{3, 12, 13, 14, 15, 1};

    //            op                  idx cnt rev n first stall_beat stall_len
    cmds[0] = '{MAT_DATA_READ_ROW,  1, 2, 0, 2, 0,  -1, 0};
    cmds[1] = '{MAT_DATA_READ_COL,  3, 2, 0, 2, 2,  -1, 0};
    cmds[2] = '{MAT_DATA_READ_ROW,  0, 0, 0, 4, 4,  -1, 0};
    cmds[3] = '{MAT_DATA_READ_DIAG, 2, 1, 0, 1, 8,  -1, 0};
    cmds[4] = '{MAT_DATA_READ_ROW,  1, 3, 0, 3, 9,   1, 3};
    cmds[5] = '{MAT_DATA_READ_ROW,  2, 1, 0, 1, 12, -1, 0};
    cmds[6] = '{MAT_DATA_READ_ROW,  0, 2, 1, 2, 13, -1, 0};

    // Reset state.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_read_op", read_op, MAT_DATA_READ_DISABLE);
    chk("rst_read_param1", read_param1, 0);
    chk("rst_read_param2", read_param2, 0);

    // Table-driven streams, including count 0, index wrap and a 3-cycle stall.
    for (int k = 0; k < 5; k++) run_cmd(cmds[k]);

    // Abort on the cycle after the first vector appears.
    @(posedge clock); #1;
    start = 1'b1; start_op = MAT_DATA_READ_ROW; start_index = 2'd0; start_count = 3'd4;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    chk("abort_first_valid", out_valid, 1);
    chk("abort_first_index", out_index, 0);
    @(posedge clock); #1;
    abort = 1'b1;
    #1;
    chk("abort_cycle_done", done, 0);
    @(posedge clock); #1;
    abort = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clock); #1;
    chk("abort_idle_done", done, 0);
    chk("abort_idle_busy", busy, 0);
    run_cmd(cmds[5]);

    // Scalar command is rejected with a single error pulse.
    start = 1'b1; start_op = MAT_DATA_READ_SCALAR; start_index = 2'd1; start_count = 3'd1;
    @(posedge clock); #1;
    start = 1'b0;
    #1;
    chk("reject_error", error, 1);
    chk("reject_busy", busy, 0);
    @(posedge clock); #1;
    chk("reject_error_clear", error, 0);
    chk("reject_busy_idle", busy, 0);
    chk("reject_out_valid", out_valid, 0);

`ifdef MAT_READER_REVERSE_EN
    run_cmd(cmds[6]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
